tqv_trng_harvester: RTL

- Bus initiator that drives the TinyQV peripheral bus of the TRNG/PUF register block (trng_kietdang) autonomously.
- Brings the TRNG out of reset, loads the seed, enables it, then repeatedly requests, polls and reads 64-bit samples.
- Samples are delivered on a valid/ready stream port.
- Sits between the TRNG peripheral and an on-chip consumer (FIFO, DMA or test harness), replacing CPU firmware polling.

---
 rtl/tqv_trng_harvester.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tqv_trng_harvester.sv
// tqv_trng_harvester: autonomous TinyQV bus initiator for the trng_kietdang
// register block. It resets, seeds and enables the TRNG, then loops forever:
// request a sample, poll status, read both sample words, acknowledge, and
// hand the 64-bit result to a valid/ready consumer.
// Optional build macro: TQV_TRNG_HARVEST_CALIB_EN adds a calibration write
// pair (count to addr 2, CALIB|EN to addr 0) before INIT.
module tqv_trng_harvester #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int CTRL_EN_BIT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [63:0] seed,
  input  logic [31:0] calib_cycles,
  output logic [5:0]  bus_address,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_write_n,
  output logic [1:0]  bus_read_n,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [63:0] smp_data,
  output logic        busy,
  output logic        error
);

  localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);

  // Peripheral register map
  localparam logic [5:0] ADDR_CTRL0  = 6'd0;
  localparam logic [5:0] ADDR_CTRL1  = 6'd1;
`ifdef TQV_TRNG_HARVEST_CALIB_EN
  localparam logic [5:0] ADDR_CALIB  = 6'd2;
`endif
  localparam logic [5:0] ADDR_SEED0  = 6'd3;
  localparam logic [5:0] ADDR_SEED1  = 6'd4;
  localparam logic [5:0] ADDR_STATUS = 6'd13;
  localparam logic [5:0] ADDR_SMP0   = 6'd14;
  localparam logic [5:0] ADDR_SMP1   = 6'd15;

  // Control register 0 bit values
  localparam logic [31:0] CTRL_RST   = 32'h1;
  localparam logic [31:0] CTRL_EN    = 32'h1 << CTRL_EN_BIT;
  localparam logic [31:0] CTRL_INIT  = 32'h8;
`ifdef TQV_TRNG_HARVEST_CALIB_EN
  localparam logic [31:0] CTRL_CALIB = 32'h10;
`endif

  localparam logic [1:0] BUS_IDLE = 2'b11;
  localparam logic [1:0] BUS_W32  = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    W_RST,
    W_SEED0,
    W_SEED1,
`ifdef TQV_TRNG_HARVEST_CALIB_EN
    W_CAL,
    W_CALGO,
`endif
    W_INIT,
    W_RUN,
    W_REQ,
    POLL,
    RD0,
    RD1,
    W_ACK,
    PUSH,
    W_OFF
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [CNT_W-1:0]   poll_cnt_inc;
  logic [63:0]        smp_data_q, smp_data_d;
  logic               error_q, error_d;

`ifndef TQV_TRNG_HARVEST_CALIB_EN
  logic unused_calib;
  assign unused_calib = ^calib_cycles;
`else
`endif

  assign poll_cnt_inc = poll_cnt_q + CNT_W'(1);

  // State register and datapath registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      poll_cnt_q <= '0;
      smp_data_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      smp_data_q <= smp_data_d;
      error_q    <= error_d;
    end
  end

  // Next-state, register updates and bus drive decoded from the current state
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    smp_data_d  = smp_data_q;
    error_d     = error_q;
    bus_address = '0;
    bus_wdata   = '0;
    bus_write_n = BUS_IDLE;
    bus_read_n  = BUS_IDLE;

    case (state_q)
      IDLE: begin
        if (start) begin
          error_d = 1'b0;
          state_d = W_RST;
        end
      end
      W_RST: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL0;
        bus_wdata   = CTRL_RST;
        state_d     = W_SEED0;
      end
      W_SEED0: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_SEED0;
        bus_wdata   = seed[31:0];
        state_d     = W_SEED1;
      end
      W_SEED1: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_SEED1;
        bus_wdata   = seed[63:32];
`ifdef TQV_TRNG_HARVEST_CALIB_EN
        state_d     = W_CAL;
`else
        state_d     = W_INIT;
`endif
      end
`ifdef TQV_TRNG_HARVEST_CALIB_EN
      W_CAL: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CALIB;
        bus_wdata   = calib_cycles;
        state_d     = W_CALGO;
      end
      W_CALGO: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL0;
        bus_wdata   = CTRL_CALIB | CTRL_EN;
        state_d     = W_INIT;
      end
`endif
      W_INIT: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL0;
        bus_wdata   = CTRL_INIT | CTRL_EN;
        state_d     = W_RUN;
      end
      W_RUN: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL0;
        bus_wdata   = CTRL_EN;
        state_d     = W_REQ;
      end
      W_REQ: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL1;
        bus_wdata   = 32'h1;
        poll_cnt_d  = '0;
        state_d     = POLL;
      end
      POLL: begin
        // Each ready cycle completes one status read; a not-ready status
        // simply rolls straight into the next read.
        bus_read_n  = BUS_W32;
        bus_address = ADDR_STATUS;
        if (bus_ready) begin
          if (bus_rdata[0]) begin
            state_d = RD0;
          end else if (poll_cnt_inc == CNT_W'(POLL_TIMEOUT)) begin
            error_d = 1'b1;
            state_d = W_OFF;
          end else begin
            poll_cnt_d = poll_cnt_inc;
          end
        end
      end
      RD0: begin
        bus_read_n  = BUS_W32;
        bus_address = ADDR_SMP0;
        if (bus_ready) begin
          smp_data_d[31:0] = bus_rdata;
          state_d          = RD1;
        end
      end
      RD1: begin
        bus_read_n  = BUS_W32;
        bus_address = ADDR_SMP1;
        if (bus_ready) begin
          smp_data_d[63:32] = bus_rdata;
          state_d           = W_ACK;
        end
      end
      W_ACK: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL1;
        bus_wdata   = 32'h0;
        state_d     = PUSH;
      end
      PUSH: begin
        // stop only matters at the handshake that retires a sample
        if (smp_ready) begin
          state_d = stop ? W_OFF : W_REQ;
        end
      end
      W_OFF: begin
        bus_write_n = BUS_W32;
        bus_address = ADDR_CTRL0;
        bus_wdata   = 32'h0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign smp_valid = (state_q == PUSH);
  assign smp_data  = smp_data_q;
  assign busy      = (state_q != IDLE);
  assign error     = error_q;

endmodule
